// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate format codes and datapath width shared by the immediate generator
package imm_pkg;
    localparam int XLEN = 32;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational RV32 immediate format mux; EXTEND_ILLEGAL_FLAG_EN adds illegal-code flag
module imm_decode
    import imm_pkg::*;
(
    input  logic [31:7]     InstrD,
    input  logic [2:0]      ImmSrcD,
`ifdef EXTEND_ILLEGAL_FLAG_EN
    output logic            ImmIllegalD,
`endif
    output logic [XLEN-1:0] ImmExtD
);

    logic w_sign;
    assign w_sign = InstrD[31];

    // Unused codes 5..7 resolve to zero so the datapath never sees X.
    always_comb begin
        ImmExtD = '0;
        case (ImmSrcD)
            IMM_I: ImmExtD = {{20{w_sign}}, InstrD[31:20]};
            IMM_S: ImmExtD = {{20{w_sign}}, InstrD[31:25], InstrD[11:7]};
            IMM_B: ImmExtD = {{19{w_sign}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J: ImmExtD = {{11{w_sign}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            IMM_U: ImmExtD = {InstrD[31:12], 12'b0};
            default: ImmExtD = '0;
        endcase
    end

`ifdef EXTEND_ILLEGAL_FLAG_EN
    assign ImmIllegalD = (ImmSrcD > IMM_U);
`endif

endmodule

// File: rtl/imm_extend_unit.sv
// rtl/imm_extend_unit.sv - decode-stage immediate generator plus D->E register; EXTEND_ILLEGAL_FLAG_EN adds illegal flag
module imm_extend_unit
    import imm_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [31:7]     InstrD,
    input  logic [2:0]      ImmSrcD,
    input  logic            StallE,
    input  logic            FlushE,
`ifdef EXTEND_ILLEGAL_FLAG_EN
    output logic            ImmIllegalD,
    output logic            ImmIllegalE,
`endif
    output logic [XLEN-1:0] ImmExtD,
    output logic [XLEN-1:0] ImmExtE
);

    logic [XLEN-1:0] w_imm_ext_d;
    logic [XLEN-1:0] r_imm_ext_e;

`ifdef EXTEND_ILLEGAL_FLAG_EN
    logic w_illegal_d;
    logic r_illegal_e;
`endif

    imm_decode u_imm_decode (
        .InstrD      (InstrD),
        .ImmSrcD     (ImmSrcD),
`ifdef EXTEND_ILLEGAL_FLAG_EN
        .ImmIllegalD (w_illegal_d),
`endif
        .ImmExtD     (w_imm_ext_d)
    );

    // Flush wins over stall so a bubble can be injected into a stalled stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_imm_ext_e <= '0;
        end else if (FlushE) begin
            r_imm_ext_e <= '0;
        end else if (!StallE) begin
            r_imm_ext_e <= w_imm_ext_d;
        end
    end

    assign ImmExtD = w_imm_ext_d;
    assign ImmExtE = r_imm_ext_e;

`ifdef EXTEND_ILLEGAL_FLAG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal_e <= 1'b0;
        end else if (FlushE) begin
            r_illegal_e <= 1'b0;
        end else if (!StallE) begin
            r_illegal_e <= w_illegal_d;
        end
    end

    assign ImmIllegalD = w_illegal_d;
    assign ImmIllegalE = r_illegal_e;
`endif

endmodule

// File: tb/tb_imm_extend_unit.sv
// tb/tb_imm_extend_unit.sv - randomized self-checking bench for imm_extend_unit against an arithmetic reference
module tb_imm_extend_unit;

    logic        clk;
    logic        reset;
    logic [31:7] InstrD;
    logic [2:0]  ImmSrcD;
    logic        StallE;
    logic        FlushE;
    logic [31:0] ImmExtD;
    logic [31:0] ImmExtE;
`ifdef EXTEND_ILLEGAL_FLAG_EN
    logic        ImmIllegalD;
    logic        ImmIllegalE;
    logic [31:0] exp_ill_e;
`endif

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_e;

    imm_extend_unit dut (
        .clk         (clk),
        .reset       (reset),
        .InstrD      (InstrD),
        .ImmSrcD     (ImmSrcD),
        .StallE      (StallE),
        .FlushE      (FlushE),
`ifdef EXTEND_ILLEGAL_FLAG_EN
        .ImmIllegalD (ImmIllegalD),
        .ImmIllegalE (ImmIllegalE),
`endif
        .ImmExtD     (ImmExtD),
        .ImmExtE     (ImmExtE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: view the field as the full instruction word and extract with shifts and masks.
    function automatic logic [31:0] ref_imm(input logic [24:0] b, input int src);
        logic        [31:0] w;
        logic signed [31:0] sw;
        logic        [31:0] sext20;
        w      = {b, 7'b0};
        sw     = w;
        sext20 = sw >>> 20;
        case (src)
            0: return sext20;
            1: return (sext20 & ~32'h1F) | ((w >> 7) & 32'h1F);
            2: return (w[31] ? 32'hFFFF_F000 : 32'h0) | (((w >> 7) & 32'h1) << 11)
                    | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
            3: return (w[31] ? 32'hFFF0_0000 : 32'h0) | (w & 32'h000F_F000)
                    | (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1);
            4: return w & 32'hFFFF_F000;
            default: return 32'h0;
        endcase
    endfunction

    // Drive one cycle, check the combinational output, then check the registered output after the edge.
    task automatic step(input string tag, input logic [24:0] b, input logic [2:0] src,
                        input logic stall, input logic flush, input logic rst);
        logic [31:0] nxt;
        logic [31:0] dexp;
        InstrD  = b;
        ImmSrcD = src;
        StallE  = stall;
        FlushE  = flush;
        reset   = rst;
        #1;
        dexp = ref_imm(b, int'(src));
        check({tag, "_D"}, ImmExtD, dexp);
        nxt = (rst || flush) ? 32'h0 : (stall ? exp_e : dexp);
`ifdef EXTEND_ILLEGAL_FLAG_EN
        check({tag, "_ILLD"}, {31'b0, ImmIllegalD}, {31'b0, (src > 3'd4)});
        begin
            logic [31:0] nill;
            nill = (rst || flush) ? 32'h0 : (stall ? exp_ill_e : {31'b0, (src > 3'd4)});
            @(posedge clk);
            #1;
            exp_ill_e = nill;
            check({tag, "_ILLE"}, {31'b0, ImmIllegalE}, exp_ill_e);
        end
`else
        @(posedge clk);
        #1;
`endif
        exp_e = nxt;
        check({tag, "_E"}, ImmExtE, exp_e);
    endtask

    localparam logic [24:0] B_COMMON = 25'b0010111110111100101001001;
    localparam logic [24:0] B_SIGN   = 25'h100_0000;

    initial begin
        logic [24:0] b_common;
        n_checks = 0;
        n_errors = 0;
        exp_e    = 32'h0;
`ifdef EXTEND_ILLEGAL_FLAG_EN
        exp_ill_e = 32'h0;
`endif
        InstrD  = '0;
        ImmSrcD = 3'd0;
        StallE  = 1'b0;
        FlushE  = 1'b0;
        reset   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_E", ImmExtE, 32'h0);

        // Directed vectors with hand-derived constants.
        b_common = B_COMMON;
        step("dir_I", b_common, 3'd0, 1'b0, 1'b0, 1'b0);
        check("const_I_E", ImmExtE, 32'h0000_02FB);
        ImmSrcD = 3'd1; #1; check("const_S", ImmExtD, 32'h0000_02E9);
        ImmSrcD = 3'd2; #1; check("const_B", ImmExtD, 32'h0000_0AE8);
        ImmSrcD = 3'd3; #1; check("const_J", ImmExtD, 32'h000C_AAFA);
        ImmSrcD = 3'd4; #1; check("const_U", ImmExtD, 32'h2FBC_A000);
        for (int c = 5; c < 8; c++) begin
            ImmSrcD = 3'(c); #1; check("const_ill", ImmExtD, 32'h0);
        end
        InstrD = B_SIGN;
        ImmSrcD = 3'd0; #1; check("sign_I", ImmExtD, 32'hFFFF_F800);
        ImmSrcD = 3'd2; #1; check("sign_B", ImmExtD, 32'hFFFF_F000);

        // Register control: load, stall, flush over stall, reset over everything.
        step("ld_I", b_common, 3'd0, 1'b0, 1'b0, 1'b0);
        check("ld_I_const", ImmExtE, 32'h0000_02FB);
        step("stall_U", b_common, 3'd4, 1'b1, 1'b0, 1'b0);
        check("stall_const", ImmExtE, 32'h0000_02FB);
        step("flush_stall", b_common, 3'd4, 1'b1, 1'b1, 1'b0);
        check("flush_const", ImmExtE, 32'h0);
        step("ld_U", b_common, 3'd4, 1'b0, 1'b0, 1'b0);
        step("rst_mid", b_common, 3'd3, 1'b0, 1'b0, 1'b1);
        check("rst_mid_const", ImmExtE, 32'h0);

        // Random instruction fields, formats and control.
        for (int i = 0; i < 400; i++) begin
            logic [24:0] rb;
            logic [2:0]  rs;
            rb = 25'($urandom);
            rs = 3'($urandom_range(0, 7));
            step("rnd", rb, rs, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 31) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
